// File: rtl/pc_stack_unit_if.sv
// Command/status bundle between the comp16 control unit and the fetch-stage PC unit.
// The control unit is the master; the PC unit is the slave.
interface pc_stack_unit_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             incr;
  logic             jmp;
  logic [WIDTH-1:0] cond;
  logic             call;
  logic             ret;
  logic             vec_req;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] next_pc;
  logic             stack_empty;
  logic             stack_full;
  logic             stk_ovf;
  logic             stk_unf;

  modport master (
    output en, incr, jmp, cond, call, ret, vec_req, target,
    input  pc_out, next_pc, stack_empty, stack_full, stk_ovf, stk_unf
  );

  modport slave (
    input  en, incr, jmp, cond, call, ret, vec_req, target,
    output pc_out, next_pc, stack_empty, stack_full, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack, stall, reset vector and forced vector jump.
// One command per cycle, resolved by fixed priority: vec_req > ret > call > jmp > incr.
module pc_stack_unit #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] JMP_VEC   = WIDTH'(16'hFF00)
) (
  input logic              clk,
  input logic              rst_n,
  pc_stack_unit_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] pc_p1;
  logic [PW-1:0]    ptr_p1;
  logic             ovf_p1;
  logic             unf_p1;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] next_pc;
  logic [AW-1:0]    top_idx;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             set_ovf;
  logic             set_unf;

  function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  assign pc_inc  = inc_wrap(pc_p1);
  assign empty   = (ptr_p1 == '0);
  assign full    = (ptr_p1 == PW'(DEPTH));
  // Low bits wrap to DEPTH-1 when the stack is full, which is exactly the top entry.
  assign top_idx = ptr_p1[AW-1:0] - AW'(1);

  always_comb begin
    next_pc = pc_p1;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (bus.vec_req) begin
      next_pc = JMP_VEC;
    end else if (bus.ret) begin
      if (empty) begin
        next_pc = pc_inc;
        set_unf = 1'b1;
      end else begin
        next_pc = stack_mem[top_idx];
        do_pop  = 1'b1;
      end
    end else if (bus.call) begin
      next_pc = bus.target;
      if (full) set_ovf = 1'b1;
      else      do_push = 1'b1;
    end else if (bus.jmp) begin
      if (bus.cond != '0) next_pc = bus.target;
      else if (bus.incr)  next_pc = pc_inc;
    end else if (bus.incr) begin
      next_pc = pc_inc;
    end
  end

  // Stage p1: architectural PC, stack pointer and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p1  <= RESET_VEC;
      ptr_p1 <= '0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else if (bus.en) begin
      pc_p1 <= next_pc;
      if (do_push)     ptr_p1 <= ptr_p1 + PW'(1);
      else if (do_pop) ptr_p1 <= ptr_p1 - PW'(1);
      ovf_p1 <= ovf_p1 | set_ovf;
      unf_p1 <= unf_p1 | set_unf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && bus.en && do_push) stack_mem[ptr_p1[AW-1:0]] <= pc_inc;
  end

  assign bus.pc_out      = pc_p1;
  assign bus.next_pc     = next_pc;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.stk_ovf     = ovf_p1;
  assign bus.stk_unf     = unf_p1;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: a reference model predicts next_pc and the
// post-edge state for every command; predictions are queued and compared after the edge.
module tb_pc_stack_unit;
  localparam int DEPTH = 8;

  typedef struct {
    logic [15:0] pc;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  exp_t        sbq[$];
  logic [15:0] mstk[$];
  logic [15:0] mpc = 16'h0000;
  logic        movf = 1'b0;
  logic        munf = 1'b0;

  pc_stack_unit_if #(.WIDTH(16)) bus ();

  pc_stack_unit #(.WIDTH(16), .DEPTH(DEPTH), .RESET_VEC(16'h0000), .JMP_VEC(16'hFF00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag);
    exp_t x;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    x = sbq.pop_front();
    chk({tag, "_pc"},    {16'h0, bus.pc_out},  {16'h0, x.pc});
    chk({tag, "_empty"}, {31'h0, bus.stack_empty}, {31'h0, x.emp});
    chk({tag, "_full"},  {31'h0, bus.stack_full},  {31'h0, x.ful});
    chk({tag, "_ovf"},   {31'h0, bus.stk_ovf},     {31'h0, x.ovf});
    chk({tag, "_unf"},   {31'h0, bus.stk_unf},     {31'h0, x.unf});
  endtask

  function automatic exp_t snapshot();
    exp_t x;
    x.pc  = mpc;
    x.emp = (mstk.size() == 0);
    x.ful = (mstk.size() == DEPTH);
    x.ovf = movf;
    x.unf = munf;
    return x;
  endfunction

  task automatic model_reset();
    mpc = 16'h0000;
    mstk.delete();
    movf = 1'b0;
    munf = 1'b0;
  endtask

  // Called just after a rising edge; leaves the bench just after the next one.
  task automatic drive(input string tag, input logic e, input logic i, input logic j,
                       input logic [15:0] c, input logic ca, input logic r, input logic v,
                       input logic [15:0] t);
    logic [15:0] np;
    logic [15:0] ra;
    bus.en = e; bus.incr = i; bus.jmp = j; bus.cond = c;
    bus.call = ca; bus.ret = r; bus.vec_req = v; bus.target = t;
    ra = mpc + 16'd1;
    np = mpc;
    if (v)                 np = 16'hFF00;
    else if (r)            np = (mstk.size() > 0) ? mstk[$] : ra;
    else if (ca)           np = t;
    else if (j)            np = (c != 16'h0) ? t : (i ? ra : mpc);
    else if (i)            np = ra;
    if (e) begin
      if (!v && r) begin
        if (mstk.size() > 0) void'(mstk.pop_back());
        else munf = 1'b1;
      end else if (!v && ca) begin
        if (mstk.size() < DEPTH) mstk.push_back(ra);
        else movf = 1'b1;
      end
      mpc = np;
    end
    #1;
    chk({tag, "_next_pc"}, {16'h0, bus.next_pc}, {16'h0, np});
    sbq.push_back(snapshot());
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask

  task automatic do_incr(input string tag);
    drive(tag, 1, 1, 0, 16'h0, 0, 0, 0, 16'h0);
  endtask
  task automatic do_goto(input string tag, input logic [15:0] t);
    drive(tag, 1, 0, 1, 16'h0001, 0, 0, 0, t);
  endtask
  task automatic do_call(input string tag, input logic [15:0] t);
    drive(tag, 1, 0, 0, 16'h0, 1, 0, 0, t);
  endtask
  task automatic do_ret(input string tag);
    drive(tag, 1, 0, 0, 16'h0, 0, 1, 0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 0; bus.incr = 0; bus.jmp = 0; bus.cond = '0;
    bus.call = 0; bus.ret = 0; bus.vec_req = 0; bus.target = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    sbq.push_back(snapshot());
    chk_state("reset");
    rst_n = 1'b1;

    do_incr("inc1");
    do_incr("inc2");
    do_incr("inc3");

    do_goto("to_ffff", 16'hFFFF);
    do_incr("wrap");

    do_goto("to_0010a", 16'h0010);
    drive("jmp_nt", 1, 1, 1, 16'h0000, 0, 0, 0, 16'h0200);
    do_goto("to_0010b", 16'h0010);
    drive("jmp_t", 1, 0, 1, 16'h0004, 0, 0, 0, 16'h0200);
    drive("jmp_nt_hold", 1, 0, 1, 16'h0000, 0, 0, 0, 16'h0300);

    do_goto("to_0010c", 16'h0010);
    do_call("call1", 16'h0100);
    do_call("call2", 16'h0300);
    do_ret("ret1");
    do_ret("ret2");

    do_goto("to_0020", 16'h0020);
    for (int k = 0; k < 9; k++) do_call($sformatf("ovf_call%0d", k), 16'h1000 + 16'(k * 16));
    for (int k = 0; k < 9; k++) do_ret($sformatf("unf_ret%0d", k));

    do_call("pcall", 16'h0400);
    drive("prio", 1, 1, 1, 16'h0001, 1, 1, 1, 16'h0777);
    drive("stall", 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0555);
    do_ret("pret");

    do_call("rcall1", 16'h0600);
    do_call("rcall2", 16'h0700);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    sbq.push_back(snapshot());
    chk_state("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_incr("rinc1");
    do_incr("rinc2");
    do_incr("rinc3");
    do_ret("rret_empty");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter unit for the comp16 core fetch stage.
- Holds a registered PC and supports increment, conditional jump, and a forced jump to a fixed vector (boot/monitor entry at 0xFF00).
- Adds what the earlier PC lacks: a hardware return-address stack (call/ret), a stall enable, a reset vector, and sticky stack-error flags.
- Drives the instruction-memory address; the control unit supplies the one-hot-ish command strobes.

Parameters:
- WIDTH, 16, PC and address width in bits.
- DEPTH, 8, return-stack entries (power of two, >=2).
- RESET_VEC, 16'h0000, PC value loaded on reset.
- JMP_VEC, 16'hFF00, target of vec_req.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; 0 = stall, all state holds.
- incr  in  1  PC <= PC+1.
- jmp  in  1  conditional jump request.
- cond  in  WIDTH  jump condition; jump taken when cond != 0.
- call  in  1  unconditional call: push PC+1, PC <= target.
- ret  in  1  return: PC <= popped address.
- vec_req  in  1  forced jump to JMP_VEC.
- target  in  WIDTH  jump/call destination.
- pc_out  out  WIDTH  current PC (registered).
- next_pc  out  WIDTH  combinational value PC will take at next edge.
- stack_empty  out  1  no entries on return stack.
- stack_full  out  1  DEPTH entries on return stack.
- stk_ovf  out  1  sticky: call attempted while full.
- stk_unf  out  1  sticky: ret attempted while empty.

Behaviour:
- Reset (async, rst_n=0): pc_out=RESET_VEC, stack pointer=0, stack_empty=1, stack_full=0, stk_ovf=0, stk_unf=0. Stack RAM contents are don't-care. Deassertion is sampled synchronously; the first update happens on the first clk edge with rst_n=1.
- All state updates occur on the rising clk edge and only when en=1. With en=0, nothing changes, including the sticky flags. next_pc still reflects the command that would execute.
- Command priority, highest first, with one action per cycle:
  1. vec_req: PC <= JMP_VEC; stack untouched.
  2. ret:
     - Stack not empty: PC <= top; ptr--.
     - Stack empty: PC <= PC+1; stk_unf <= 1.
  3. call:
     - Stack not full: push PC+1; ptr++; PC <= target.
     - Stack full: PC <= target; push dropped; ptr unchanged; stk_ovf <= 1.
  4. jmp:
     - cond != 0: PC <= target.
     - cond == 0: PC <= PC+1 if incr=1, else hold.
  5. incr: PC <= PC+1.
  6. None: hold.
- Lower-priority strobes asserted in the same cycle are ignored and have no side effects.
- Arithmetic: PC+1 is modulo 2^WIDTH, so all-ones wraps to 0. A pushed return address wraps the same way.
- Stack: LIFO, ptr width clog2(DEPTH)+1.
  - stack_full = (ptr==DEPTH).
  - stack_empty = (ptr==0).
  - Flags are registered state and update in the same edge as ptr.
- Latency:
  - pc_out reflects a command one cycle after it is sampled.
  - next_pc is zero-latency combinational.
- Sticky flags clear only on reset.
- Reset mid-operation: a reset asserted in the middle of a call/ret sequence discards the stack (ptr=0) immediately, asynchronously.

Test Plan:
- Reset/increment: assert rst_n=0 mid-run, then release and hold incr=1 for 3 cycles -> pc_out 0x0000 immediately, then 0x0001, 0x0002, 0x0003. Separately, set PC=0xFFFF and apply incr -> pc_out 0x0000.
- Conditional jump: at PC=0x0010, apply jmp with target=0x0200.
  - cond=0x0000 and incr=1 -> pc_out 0x0011.
  - cond=0x0004 -> pc_out 0x0200.
  - In both cases next_pc equals the value one cycle before pc_out shows it.
- Call/ret nesting: at PC=0x0010, call target 0x0100; at 0x0100, call target 0x0300; then ret, ret -> pc_out sequence 0x0100, 0x0300, 0x0101, 0x0011. stack_empty reads 0 after the first call and 1 after the final ret.
- Overflow/underflow (DEPTH=8): issue 9 calls -> stack_full=1 after the 8th call, stk_ovf=1 after the 9th, and PC=target each time. Then issue 9 rets -> the first 8 return in LIFO order, and the 9th gives PC+1 with stk_unf=1.
- Priority/stall:
  - vec_req, ret and call together -> pc_out 0xFF00, ptr unchanged.
  - en=0 with call asserted -> pc_out and ptr hold, next_pc=target.
